// File: rtl/tsc_pkg.sv
// Shared edge-mode encodings and sizing helpers for the timestamp capture array.
package tsc_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Cycles from a pin transition to its detection cycle.
    function automatic int unsigned sync_latency(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

    // Extra MSB distinguishes full from empty when the index bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tsc_channel_fifo.sv
// One event channel: synchroniser, edge qualifier, timestamp FIFO and sticky overflow.
// With TSC_LATENCY_COMP_EN defined, stored stamps are backdated by the sync latency.
module tsc_channel_fifo
    import tsc_pkg::*;
#(
    parameter int unsigned pWIDTH       = 64,
    parameter int unsigned pDEPTH       = 4,
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              event_pin,
    input  logic [1:0]        edge_mode,
    input  logic              ack,
    input  logic              clr_ovf,
    input  logic [pWIDTH-1:0] counter,
    output logic [pWIDTH-1:0] ts,
    output logic              rdy,
    output logic              ovf
);

    localparam int unsigned LAT     = sync_latency(pSYNC_STAGES);
    localparam int unsigned PW      = ptr_width(pDEPTH);
    localparam int unsigned AW      = PW - 1;
    localparam int unsigned PRIME_W = $clog2(LAT + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(LAT);

    logic [pSYNC_STAGES-1:0] sync_q;
    logic                    sync_out;
    logic                    delay_q;
    logic [PRIME_W-1:0]      prime_q;
    logic                    armed;
    logic                    rise_q;
    logic                    fall_q;
    logic                    hit;

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              ovf_q;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [pWIDTH-1:0] stamp;

    assign sync_out = sync_q[pSYNC_STAGES-1];
    assign armed    = (prime_q == PRIME_DONE);

    // Edge flags are registered so detection lands LAT cycles after the pin moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
            prime_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[pSYNC_STAGES-2:0], event_pin};
            delay_q <= sync_out;
            if (!armed) begin
                prime_q <= prime_q + 1'b1;
            end
            rise_q  <= armed & sync_out & ~delay_q;
            fall_q  <= armed & ~sync_out & delay_q;
        end
    end

    always_comb begin
        case (edge_mode)
            EDGE_RISE: hit = rise_q;
            EDGE_FALL: hit = fall_q;
            EDGE_BOTH: hit = rise_q | fall_q;
            default:   hit = 1'b0;
        endcase
    end

`ifdef TSC_LATENCY_COMP_EN
    assign stamp = counter - pWIDTH'(LAT);
`else
    assign stamp = counter;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ack & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push  = hit & (~full | pop);
    assign drop  = hit & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= stamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign ts  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign rdy = ~empty;
    assign ovf = ovf_q;

endmodule

// File: rtl/timestamp_capture_array.sv
// Multi-channel event timestamper: shared free-running timebase, one FIFO per channel.
// Optional TSC_LATENCY_COMP_EN backdates stored stamps to the pin transition.
module timestamp_capture_array
    import tsc_pkg::*;
#(
    parameter int unsigned pCHANNELS    = 4,
    parameter int unsigned pWIDTH       = 64,
    parameter int unsigned pDEPTH       = 4,
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [pCHANNELS-1:0]          iEVENT,
    input  logic [2*pCHANNELS-1:0]        iEDGE,
    input  logic [pCHANNELS-1:0]          iACK,
    input  logic [pCHANNELS-1:0]          iCLR_OVF,
    output logic [pCHANNELS*pWIDTH-1:0]   oTS,
    output logic [pCHANNELS-1:0]          oRDY,
    output logic [pCHANNELS-1:0]          oOVF,
    output logic [pWIDTH-1:0]             oCOUNTER
);

    logic [pWIDTH-1:0] counter_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_q + 1'b1;
        end
    end

    assign oCOUNTER = counter_q;

    for (genvar c = 0; c < pCHANNELS; c++) begin : g_chan
        tsc_channel_fifo #(
            .pWIDTH       (pWIDTH),
            .pDEPTH       (pDEPTH),
            .pSYNC_STAGES (pSYNC_STAGES)
        ) u_chan (
            .clk       (iCLK),
            .rst       (iRST),
            .event_pin (iEVENT[c]),
            .edge_mode (iEDGE[2*c +: 2]),
            .ack       (iACK[c]),
            .clr_ovf   (iCLR_OVF[c]),
            .counter   (counter_q),
            .ts        (oTS[c*pWIDTH +: pWIDTH]),
            .rdy       (oRDY[c]),
            .ovf       (oOVF[c])
        );
    end

endmodule

// File: tb/tb_timestamp_capture_array.sv
// Bench for timestamp_capture_array: directed table plus randomized traffic against a queue model.
module tb_timestamp_capture_array;
    import tsc_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned D   = 4;
    localparam int unsigned S   = 2;
    localparam int unsigned LAT = S + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   ev;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   ack;
    logic [NCH-1:0]   clr;
    logic [NCH*W-1:0] ts;
    logic [NCH-1:0]   rdy;
    logic [NCH-1:0]   ovf;
    logic [W-1:0]     counter;

    always #5 clk = ~clk;

    timestamp_capture_array #(
        .pCHANNELS    (NCH),
        .pWIDTH       (W),
        .pDEPTH       (D),
        .pSYNC_STAGES (S)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iEVENT   (ev),
        .iEDGE    (mode),
        .iACK     (ack),
        .iCLR_OVF (clr),
        .oTS      (ts),
        .oRDY     (rdy),
        .oOVF     (ovf),
        .oCOUNTER (counter)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel list of queued stamps and a log of pin values by cycle.
    logic [W-1:0]   m_fifo [NCH][D];
    int             m_n [NCH];
    bit             m_pin [NCH][8];
    int             m_cyc;
    logic [W-1:0]   m_cnt;
    logic [NCH-1:0] m_ovf;

    typedef struct {
        logic [1:0] emode;
        int         width;
        int         n;
        int         off0;
        int         off1;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int ch, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) begin
                $display("FAIL %s ch%0d: got %0h want %0h (t=%0t)", name, ch, act, exp, $time);
            end
        end
    endtask

    function automatic logic [W-1:0] exp_stamp(input logic [W-1:0] pin_cnt);
`ifdef TSC_LATENCY_COMP_EN
        return pin_cnt;
`else
        return pin_cnt + W'(LAT);
`endif
    endfunction

    task automatic model_cycle();
        if (rst) begin
            m_cnt = '0;
            m_cyc = 0;
            m_ovf = '0;
            for (int c = 0; c < NCH; c++) m_n[c] = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            int  j;
            bit  det;
            bit  pop;
            bit  was_full;
            logic [1:0] md;
            m_pin[c][m_cyc % 8] = ev[c];
            j   = m_cyc - int'(LAT);
            det = 1'b0;
            md  = mode[2*c +: 2];
            // A pin change in cycle j (j >= 1 after reset) is detected LAT cycles later.
            if (j >= 1 && m_pin[c][j % 8] != m_pin[c][(j - 1) % 8]) begin
                if (m_pin[c][j % 8]) det = (md == EDGE_RISE) || (md == EDGE_BOTH);
                else                 det = (md == EDGE_FALL) || (md == EDGE_BOTH);
            end
            pop      = ack[c] && (m_n[c] > 0);
            was_full = (m_n[c] == D);
            if (pop) begin
                for (int k = 0; k < D - 1; k++) m_fifo[c][k] = m_fifo[c][k+1];
                m_n[c]--;
            end
            if (det && was_full && !pop) begin
                m_ovf[c] = 1'b1;
            end else begin
                if (det) begin
`ifdef TSC_LATENCY_COMP_EN
                    m_fifo[c][m_n[c]] = m_cnt - W'(LAT);
`else
                    m_fifo[c][m_n[c]] = m_cnt;
`endif
                    m_n[c]++;
                end
                if (clr[c]) m_ovf[c] = 1'b0;
            end
        end
        m_cnt = m_cnt + 1'b1;
        m_cyc++;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check("counter", 0, 64'(counter), 64'(m_cnt));
        for (int c = 0; c < NCH; c++) begin
            check("model_rdy", c, 64'(rdy[c]), 64'(m_n[c] > 0));
            check("model_ovf", c, 64'(ovf[c]), 64'(m_ovf[c]));
            if (m_n[c] > 0) check("model_ts", c, 64'(ts[c*W +: W]), 64'(m_fifo[c][0]));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_expect(input string name, input int c, input logic [W-1:0] exp);
        check({name, "_rdy"}, c, 64'(rdy[c]), 64'd1);
        check(name, c, 64'(ts[c*W +: W]), 64'(exp));
        ack[c] = 1'b1;
        tick();
        ack[c] = 1'b0;
    endtask

    task automatic wait_counter(input logic [W-1:0] target);
        int n = 0;
        while (counter !== target && n < 70000) begin
            tick();
            n++;
        end
        check("wait_counter", 0, 64'(counter), 64'(target));
    endtask

    initial begin
        logic [W-1:0] s [6];
        logic [W-1:0] t0;
        logic [3:0]   r;

        vecs[0] = '{EDGE_RISE, 3, 1, 0, 0};
        vecs[1] = '{EDGE_FALL, 3, 1, 3, 0};
        vecs[2] = '{EDGE_BOTH, 2, 2, 0, 2};
        vecs[3] = '{EDGE_OFF,  5, 0, 0, 0};
        vecs[4] = '{EDGE_BOTH, 5, 2, 0, 5};

        rst  = 1'b1;
        ev   = '0;
        mode = '0;
        ack  = '0;
        clr  = '0;

        // Pin high through reset must not look like a rising edge.
        ev[0]         = 1'b1;
        mode[1:0]     = EDGE_RISE;
        do_reset();
        check("reset_rdy", 0, 64'(rdy), 64'd0);
        check("reset_ovf", 0, 64'(ovf), 64'd0);
        check("reset_ts", 0, 64'(ts), 64'd0);
        check("reset_counter", 0, 64'(counter), 64'd0);
        ticks(10);
        check("held_high_rdy", 0, 64'(rdy[0]), 64'd0);

        // Rising edge while counter is 100.
        ev = '0;
        do_reset();
        wait_counter(W'(100));
        ev[0] = 1'b1;
        ticks(3);
        check("lat_rdy_early", 0, 64'(rdy[0]), 64'd0);
        tick();
        check("lat_rdy", 0, 64'(rdy[0]), 64'd1);
        check("lat_ts", 0, 64'(ts[0 +: W]), 64'(exp_stamp(W'(100))));
        ev[0] = 1'b0;
        pop_expect("lat_pop", 0, exp_stamp(W'(100)));
        check("lat_empty", 0, 64'(rdy[0]), 64'd0);

        // Both-edge pulse of 4 cycles on channel 1.
        mode[3:2] = EDGE_BOTH;
        ticks(2);
        t0    = counter;
        ev[1] = 1'b1;
        ticks(4);
        ev[1] = 1'b0;
        ticks(8);
        pop_expect("both_first", 1, exp_stamp(t0));
        check("both_rdy_mid", 1, 64'(rdy[1]), 64'd1);
        pop_expect("both_second", 1, exp_stamp(t0 + W'(4)));
        check("both_rdy_end", 1, 64'(rdy[1]), 64'd0);

        // Table of edge modes on channel 2.
        for (int v = 0; v < 5; v++) begin
            mode[5:4] = vecs[v].emode;
            ticks(2);
            t0    = counter;
            ev[2] = 1'b1;
            ticks(vecs[v].width);
            ev[2] = 1'b0;
            ticks(8);
            if (vecs[v].n >= 1) pop_expect("tbl_e0", 2, exp_stamp(t0 + W'(vecs[v].off0)));
            if (vecs[v].n >= 2) pop_expect("tbl_e1", 2, exp_stamp(t0 + W'(vecs[v].off1)));
            check("tbl_empty", 2, 64'(rdy[2]), 64'd0);
        end

        // Overflow on channel 3: five edges into a four-deep FIFO.
        mode[7:6] = EDGE_RISE;
        ticks(2);
        for (int i = 0; i < 5; i++) begin
            s[i]  = counter;
            ev[3] = 1'b1;
            ticks(2);
            ev[3] = 1'b0;
            ticks(2);
        end
        ticks(6);
        check("ovf_set", 3, 64'(ovf[3]), 64'd1);
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        check("ovf_clear", 3, 64'(ovf[3]), 64'd0);
        for (int i = 0; i < 4; i++) pop_expect("ovf_keep", 3, exp_stamp(s[i]));
        check("ovf_drained", 3, 64'(rdy[3]), 64'd0);

        // Refill, then push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) begin
            s[i]  = counter;
            ev[3] = 1'b1;
            ticks(2);
            ev[3] = 1'b0;
            ticks(2);
        end
        ticks(6);
        s[5]  = counter;
        ev[3] = 1'b1;
        ticks(2);
        ev[3] = 1'b0;
        tick();
        ack[3] = 1'b1;
        tick();
        ack[3] = 1'b0;
        check("full_pushpop_ovf", 3, 64'(ovf[3]), 64'd0);
        for (int i = 1; i < 4; i++) pop_expect("full_keep", 3, exp_stamp(s[i]));
        pop_expect("full_newest", 3, exp_stamp(s[5]));
        check("full_drained", 3, 64'(rdy[3]), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mode = 8'($urandom);
            r   = 4'($urandom & $urandom);
            ev  = ev ^ r;
            ack = 4'($urandom) & 4'($urandom | $urandom);
            clr = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst  = 1'b0;
        ev   = '0;
        mode = '0;
        mode[1:0] = EDGE_BOTH;
        ack  = '1;
        clr  = '1;
        ticks(10);
        ack  = '0;
        clr  = '0;
        tick();

        // Captures that straddle the timebase wrap.
        wait_counter(W'(16'hFFFC));
        ev[0] = 1'b1;
        tick();
        ev[0] = 1'b0;
        ticks(6);
        pop_expect("wrap_first", 0, exp_stamp(W'(16'hFFFC)));
        pop_expect("wrap_second", 0, exp_stamp(W'(16'hFFFD)));
        check("wrap_ovf", 0, 64'(ovf[0]), 64'd0);

        // Simultaneous edges; channel 3 is off; then reset with entries queued.
        mode = {EDGE_OFF, EDGE_RISE, EDGE_RISE, EDGE_RISE};
        do_reset();
        ticks(6);
        t0 = counter;
        ev = '1;
        ticks(5);
        check("sim_rdy", 0, 64'(rdy), 64'h7);
        for (int c = 0; c < 3; c++) check("sim_ts", c, 64'(ts[c*W +: W]), 64'(exp_stamp(t0)));
        ev = '0;
        do_reset();
        check("midrst_rdy", 0, 64'(rdy), 64'd0);
        check("midrst_ts", 0, 64'(ts), 64'd0);
        check("midrst_counter", 0, 64'(counter), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
